forward_ex_unit: RTL and testbench

FORWARD_EX_UNIT -- requirements
Module: forward_ex_unit

---
 rtl/fwd_pkg.sv | 8 +
 rtl/fwd_operand_mux.sv | 31 +++
 rtl/forward_ex_unit.sv | 108 ++++++++++
 tb/tb_forward_ex_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared widths, forwarding-select and load-use FSM encodings for forward_ex_unit.
// Contents: XLEN, REG_AW, fwd_sel_e {FWD_RF, FWD_EX_MEM, FWD_MEM_WB}, fwd_state_e {RUN, HOLD}.
package fwd_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    typedef enum logic [1:0] {FWD_RF, FWD_EX_MEM, FWD_MEM_WB} fwd_sel_e;
    typedef enum logic {RUN, HOLD} fwd_state_e;
endpackage

// File: rtl/fwd_operand_mux.sv
// fwd_operand_mux: picks one EX operand from EX/MEM, MEM/WB or the captured register data.
// Ports:
//   rs, rs_data                          - registered source index and captured data
//   mem_rd, mem_reg_write, forward_ex_mem - EX/MEM result path (highest priority)
//   wb_rd, wb_reg_write, forward_mem_wb   - MEM/WB write-back path
//   op                                    - selected operand (0 whenever rs is x0)
//   sel                                   - which source was chosen
module fwd_operand_mux
    import fwd_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   forward_ex_mem,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   forward_mem_wb,
    output logic [XLEN-1:0]   op,
    output fwd_sel_e          sel
);
    logic w_zero;
    assign w_zero = (rs == '0);
    // rs != 0 already rules out a match against a zero destination.
    assign sel = w_zero                               ? FWD_RF     :
                 (mem_reg_write && mem_rd == rs)      ? FWD_EX_MEM :
                 (wb_reg_write && wb_rd == rs)        ? FWD_MEM_WB : FWD_RF;
    assign op  = w_zero                ? '0             :
                 (sel == FWD_EX_MEM)   ? forward_ex_mem :
                 (sel == FWD_MEM_WB)   ? forward_mem_wb : rs_data;
endmodule

// File: rtl/forward_ex_unit.sv
// forward_ex_unit: EX operand register with forwarding muxes and a one-bubble load-use stall FSM.
// Ports:
//   clk, rst_n                                   - clock, async active-low reset
//   id_valid, id_rs1/2, id_rs1/2_data            - instruction in ID and its register-file reads
//   ex_rd, ex_mem_read, ex_reg_write             - destination of the instruction in EX
//   mem_rd, mem_reg_write, forward_ex_mem        - EX/MEM result path
//   wb_rd, wb_reg_write, forward_mem_wb          - MEM/WB write-back path
//   stall                                        - hold PC and IF/ID, bubble into EX
//   ex_valid, op_a, op_b                         - EX operand register validity and forwarded operands
//   stall_count                                  - load-use stall counter
// Config: define FORWARD_STALL_CNT_EN to build the saturating stall counter; otherwise stall_count is 0.
module forward_ex_unit
    import fwd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [31:0] forward_ex_mem,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic [31:0] forward_mem_wb,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] stall_count
);
    fwd_state_e        r_state, w_state_nxt;
    logic [REG_AW-1:0] r_rs1, r_rs2;
    logic [XLEN-1:0]   r_rs1_data, r_rs2_data;
    logic              r_valid;
    logic              w_hazard;
    logic [XLEN-1:0]   w_wt1, w_wt2;
    fwd_sel_e          w_sel_a, w_sel_b;
    logic              w_unused;

    // ex_reg_write is implied by ex_mem_read for a load; the selections are kept for visibility only.
    assign w_unused = ^{ex_reg_write, w_sel_a, w_sel_b};

    assign w_hazard = id_valid && ex_mem_read && (ex_rd != '0) && (ex_rd == id_rs1 || ex_rd == id_rs2);

    // Mealy stall from RUN only; gating with rst_n keeps stall low while reset is held.
    always_comb begin
        stall       = rst_n && (r_state == RUN) && w_hazard;
        w_state_nxt = (r_state == RUN && w_hazard) ? HOLD : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    // Write-through: a value retiring in WB this cycle is newer than the register-file read.
    assign w_wt1 = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs1) ? forward_mem_wb : id_rs1_data;
    assign w_wt2 = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs2) ? forward_mem_wb : id_rs2_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || stall) begin
            r_valid    <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else begin
            r_valid    <= id_valid;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rs1_data <= w_wt1;
            r_rs2_data <= w_wt2;
        end
    end

    assign ex_valid = r_valid;

    fwd_operand_mux u_mux_a (
        .rs(r_rs1), .rs_data(r_rs1_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .forward_ex_mem(forward_ex_mem),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .forward_mem_wb(forward_mem_wb),
        .op(op_a), .sel(w_sel_a)
    );

    fwd_operand_mux u_mux_b (
        .rs(r_rs2), .rs_data(r_rs2_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .forward_ex_mem(forward_ex_mem),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .forward_mem_wb(forward_mem_wb),
        .op(op_b), .sel(w_sel_b)
    );

`ifdef FORWARD_STALL_CNT_EN
    logic [XLEN-1:0] r_stall_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_stall_count <= '0;
        else if (stall && r_stall_count != '1) r_stall_count <= r_stall_count + 1'b1;
    end
    assign stall_count = r_stall_count;
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_forward_ex_unit.sv
// tb_forward_ex_unit: directed scenarios plus randomized run against a behavioural pipeline model.
module tb_forward_ex_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_reg_write;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [31:0] forward_ex_mem;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] forward_mem_wb;
    logic        stall, ex_valid;
    logic [31:0] op_a, op_b, stall_count;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef FORWARD_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    forward_ex_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .forward_ex_mem(forward_ex_mem),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .forward_mem_wb(forward_mem_wb),
        .stall(stall), .ex_valid(ex_valid), .op_a(op_a), .op_b(op_b), .stall_count(stall_count)
    );

    // Reference: operand as seen by the pipeline, youngest producer wins, x0 reads as zero.
    function automatic logic [31:0] ref_op(input logic [4:0] rs, input logic [31:0] data,
                                           input logic [4:0] mrd, input logic mw, input logic [31:0] mv,
                                           input logic [4:0] wrd, input logic ww, input logic [31:0] wv);
        if (rs == 0) return 32'd0;
        if (mw && mrd == rs) return mv;
        if (ww && wrd == rs) return wv;
        return data;
    endfunction

    task automatic idle;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0;
        ex_rd = 0; ex_mem_read = 0; ex_reg_write = 0;
        mem_rd = 0; mem_reg_write = 0; forward_ex_mem = 0;
        wb_rd = 0; wb_reg_write = 0; forward_mem_wb = 0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_reset;
        idle();
        id_valid = 1; id_rs1 = 2; id_rs2 = 2; ex_rd = 2; ex_mem_read = 1;
        rst_n = 0;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall); end
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ex_valid: got %0b want 0", ex_valid); end
        n_tests++; if (op_a !== 32'd0 || op_b !== 32'd0) begin n_fail++; $display("FAIL rst_ops: got %h/%h want 0/0", op_a, op_b); end
        n_tests++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", stall_count); end
        idle();
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_ex_mem_forward;
        idle();
        id_valid = 1; id_rs1 = 5; id_rs1_data = 32'h1;
        step();
        idle();
        mem_rd = 5; mem_reg_write = 1; forward_ex_mem = 32'h1234;
        #1;
        n_tests++; if (op_a !== 32'h1234) begin n_fail++; $display("FAIL exmem_fwd: got %h want 00001234", op_a); end
        n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL exmem_valid: got %0b want 1", ex_valid); end
    endtask

    task automatic test_priority;
        idle();
        id_valid = 1; id_rs2 = 7; id_rs2_data = 32'h3;
        step();
        idle();
        mem_rd = 7; mem_reg_write = 1; forward_ex_mem = 32'hAAAA;
        wb_rd = 7; wb_reg_write = 1; forward_mem_wb = 32'hBBBB;
        #1;
        n_tests++; if (op_b !== 32'hAAAA) begin n_fail++; $display("FAIL prio_exmem: got %h want 0000aaaa", op_b); end
        mem_reg_write = 0;
        #1;
        n_tests++; if (op_b !== 32'hBBBB) begin n_fail++; $display("FAIL prio_memwb: got %h want 0000bbbb", op_b); end
        wb_reg_write = 0;
        #1;
        n_tests++; if (op_b !== 32'h3) begin n_fail++; $display("FAIL prio_rf: got %h want 00000003", op_b); end
    endtask

    task automatic test_x0;
        idle();
        id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h5;
        step();
        idle();
        mem_rd = 0; mem_reg_write = 1; forward_ex_mem = 32'hFFFF;
        wb_rd = 0; wb_reg_write = 1; forward_mem_wb = 32'hEEEE;
        #1;
        n_tests++; if (op_a !== 32'd0) begin n_fail++; $display("FAIL x0_op_a: got %h want 0", op_a); end
    endtask

    task automatic test_load_use;
        idle();
        apply_reset();
        id_valid = 1; id_rs1 = 1; id_rs2 = 3; ex_rd = 3; ex_mem_read = 1;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b want 1", stall); end
        step();
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_hold: got %0b want 0", stall); end
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %0b want 0", ex_valid); end
        ex_mem_read = 0;
        step();
        n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_resume: got %0b want 1", ex_valid); end
        n_tests++; if (stall_count !== (CNT_EN ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL lu_count1: got %0d want %0d", stall_count, CNT_EN ? 1 : 0); end
        id_rs1 = 4; id_rs2 = 4; ex_rd = 4; ex_mem_read = 1;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_both_stall: got %0b want 1", stall); end
        step();
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_both_single: got %0b want 0", stall); end
        ex_mem_read = 0;
        step();
        n_tests++; if (stall_count !== (CNT_EN ? 32'd2 : 32'd0)) begin n_fail++; $display("FAIL lu_count2: got %0d want %0d", stall_count, CNT_EN ? 2 : 0); end
        id_valid = 0; ex_mem_read = 1;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_novalid: got %0b want 0", stall); end
        step();
    endtask

    task automatic test_write_through;
        idle();
        id_valid = 1; id_rs1 = 9; id_rs1_data = 32'h0;
        wb_rd = 9; wb_reg_write = 1; forward_mem_wb = 32'hCAFE;
        step();
        idle();
        #1;
        n_tests++; if (op_a !== 32'hCAFE) begin n_fail++; $display("FAIL wt_op_a: got %h want 0000cafe", op_a); end
    endtask

    task automatic test_reset_mid_hold;
        idle();
        id_valid = 1; id_rs1 = 6; ex_rd = 6; ex_mem_read = 1;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rmh_pre: got %0b want 1", stall); end
        step();
        rst_n = 0;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmh_stall: got %0b want 0", stall); end
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rmh_valid: got %0b want 0", ex_valid); end
        n_tests++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL rmh_count: got %0d want 0", stall_count); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rmh_restall: got %0b want 1", stall); end
        step();
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmh_hold: got %0b want 0", stall); end
        idle();
        step();
    endtask

    task automatic test_random;
        logic [4:0]  m_rs1, m_rs2;
        logic [31:0] m_d1, m_d2, m_cnt, e_a, e_b;
        logic        m_valid, m_prev_stall, e_stall;
        idle();
        apply_reset();
        m_rs1 = 0; m_rs2 = 0; m_d1 = 0; m_d2 = 0; m_valid = 0; m_prev_stall = 0; m_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            id_valid = 1'($urandom_range(0, 1));
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rs1_data = $urandom; id_rs2_data = $urandom;
            ex_rd = 5'($urandom_range(0, 3)); ex_mem_read = 1'($urandom_range(0, 1));
            ex_reg_write = ex_mem_read | 1'($urandom_range(0, 1));
            mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom_range(0, 1)); forward_ex_mem = $urandom;
            wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom_range(0, 1)); forward_mem_wb = $urandom;
            #1;
            // A load in EX feeding ID costs one bubble, but never two stalls in a row.
            e_stall = !m_prev_stall && id_valid && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
            e_a = ref_op(m_rs1, m_d1, mem_rd, mem_reg_write, forward_ex_mem, wb_rd, wb_reg_write, forward_mem_wb);
            e_b = ref_op(m_rs2, m_d2, mem_rd, mem_reg_write, forward_ex_mem, wb_rd, wb_reg_write, forward_mem_wb);
            n_tests++; if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", i, stall, e_stall); end
            n_tests++; if (op_a !== e_a) begin n_fail++; $display("FAIL rnd_op_a[%0d]: got %h want %h", i, op_a, e_a); end
            n_tests++; if (op_b !== e_b) begin n_fail++; $display("FAIL rnd_op_b[%0d]: got %h want %h", i, op_b, e_b); end
            n_tests++; if (ex_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, ex_valid, m_valid); end
            n_tests++; if (stall_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, stall_count, m_cnt); end
            @(posedge clk);
            if (e_stall) begin
                m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_d1 = 0; m_d2 = 0;
                if (CNT_EN && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end else begin
                m_valid = id_valid; m_rs1 = id_rs1; m_rs2 = id_rs2;
                m_d1 = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs1) ? forward_mem_wb : id_rs1_data;
                m_d2 = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs2) ? forward_mem_wb : id_rs2_data;
            end
            m_prev_stall = e_stall;
            #1;
        end
    endtask

    initial begin
        idle();
        rst_n = 1;
        test_reset();
        test_ex_mem_forward();
        test_priority();
        test_x0();
        test_load_use();
        test_write_through();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
